// File: rtl/bp_trace_unit.sv
// rtl/bp_trace_unit.sv - statement trace recorder with breakpoint table and halt control
// Events are recorded and breakpoint-matched only while running; a hit stalls until resume.
module bp_trace_unit #(
  parameter int ID_WIDTH = 32,
  parameter int DEPTH    = 8,
  parameter int NUM_BP   = 4,
  localparam int SW = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trace_valid,
  input  logic [ID_WIDTH-1:0] trace_id,
  input  logic                bp_wr,
  input  logic [SW-1:0]       bp_idx,
  input  logic [ID_WIDTH-1:0] bp_id,
  input  logic                bp_en,
  input  logic                resume,
  output logic                halt,
  output logic [SW-1:0]       hit_slot,
  output logic [ID_WIDTH-1:0] hit_id,
  output logic                rd_valid,
  output logic [ID_WIDTH-1:0] rd_id,
  input  logic                rd_ready,
  output logic [PW:0]         count,
  output logic                overflow,
  input  logic                clr_overflow
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [ID_WIDTH-1:0] bp_id_q [NUM_BP];
  logic [NUM_BP-1:0]   bp_en_q;
  logic [ID_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]         count_q, count_d;
  logic                rd_valid_q, rd_valid_d;
  logic [ID_WIDTH-1:0] rd_id_q, rd_id_d;
  logic                overflow_q, overflow_d;
  logic [SW-1:0]       hit_slot_q, hit_slot_d;
  logic [ID_WIDTH-1:0] hit_id_q, hit_id_d;

  logic          accept, match, pop, push, full, drop;
  logic [SW-1:0] match_slot;

  // Scan downward so the lowest matching slot is the one that sticks.
  always_comb begin
    match      = 1'b0;
    match_slot = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en_q[i] && (bp_id_q[i] == trace_id)) begin
        match      = 1'b1;
        match_slot = SW'(i);
      end
    end
  end

  assign accept = trace_valid && (state_q == RUN);
  assign pop    = rd_valid_q && rd_ready;
  assign full   = (count_q == (PW + 1)'(DEPTH));
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    rd_valid_d = (count_d != '0);
    // The head slot may be the one being written this cycle; memory has not caught up yet.
    rd_id_d = rd_id_q;
    if (rd_valid_d) begin
      if (push && (rd_ptr_d == wr_ptr_q)) rd_id_d = trace_id;
      else                                rd_id_d = mem_q[rd_ptr_d];
    end
    overflow_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);
  end

  always_comb begin
    state_d    = state_q;
    hit_slot_d = hit_slot_q;
    hit_id_d   = hit_id_q;
    case (state_q)
      RUN: begin
        if (accept && match) begin
          state_d    = HALTED;
          hit_slot_d = match_slot;
          hit_id_d   = trace_id;
        end
      end
      HALTED: begin
        if (resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= trace_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      bp_en_q    <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_id_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
      overflow_q <= 1'b0;
      hit_slot_q <= '0;
      hit_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
      overflow_q <= overflow_d;
      hit_slot_q <= hit_slot_d;
      hit_id_q   <= hit_id_d;
      if (bp_wr && (int'(bp_idx) < NUM_BP)) begin
        bp_id_q[bp_idx] <= bp_id;
        bp_en_q[bp_idx] <= bp_en;
      end
    end
  end

  assign halt     = (state_q == HALTED);
  assign hit_slot = hit_slot_q;
  assign hit_id   = hit_id_q;
  assign rd_valid = rd_valid_q;
  assign rd_id    = rd_id_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bp_trace_unit.sv
// tb/tb_bp_trace_unit.sv - scoreboard bench for bp_trace_unit
module tb_bp_trace_unit;
  localparam int IW = 32;
  localparam int D  = 8;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          trace_valid = 1'b0;
  logic [IW-1:0] trace_id = '0;
  logic          bp_wr = 1'b0;
  logic [1:0]    bp_idx = '0;
  logic [IW-1:0] bp_id = '0;
  logic          bp_en = 1'b0;
  logic          resume = 1'b0;
  logic          halt;
  logic [1:0]    hit_slot;
  logic [IW-1:0] hit_id;
  logic          rd_valid;
  logic [IW-1:0] rd_id;
  logic          rd_ready = 1'b0;
  logic [3:0]    count;
  logic          overflow;
  logic          clr_overflow = 1'b0;

  always #5 clk = ~clk;

  bp_trace_unit #(.ID_WIDTH(IW), .DEPTH(D), .NUM_BP(NB)) dut (
    .clk(clk), .rst(rst), .trace_valid(trace_valid), .trace_id(trace_id),
    .bp_wr(bp_wr), .bp_idx(bp_idx), .bp_id(bp_id), .bp_en(bp_en),
    .resume(resume), .halt(halt), .hit_slot(hit_slot), .hit_id(hit_id),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_ready(rd_ready), .count(count),
    .overflow(overflow), .clr_overflow(clr_overflow)
  );

  int total = 0;
  int bad   = 0;

  logic [IW-1:0] exp_q[$];
  bit            m_halt;
  int            m_slot;
  logic [IW-1:0] m_hid;
  bit            m_ovf;
  logic [IW-1:0] m_bid [NB];
  bit            m_ben [NB];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic bp_set(input int idx, input logic [IW-1:0] id, input bit en);
    bp_wr  = 1'b1;
    bp_idx = 2'(idx);
    bp_id  = id;
    bp_en  = en;
  endtask

  task automatic step(input bit tv, input logic [IW-1:0] tid, input bit rdy,
                      input bit res = 0, input bit clr = 0, input bit r = 0);
    int hit;
    bit acc;
    trace_valid = tv; trace_id = tid; rd_ready = rdy;
    resume = res; clr_overflow = clr; rst = r;
    if (r) begin
      exp_q.delete();
      m_halt = 0; m_slot = 0; m_hid = '0; m_ovf = 0;
      for (int i = 0; i < NB; i++) begin m_bid[i] = '0; m_ben[i] = 0; end
    end else begin
      if (rdy && exp_q.size() > 0) chk("pop_id", rd_id, exp_q.pop_front());
      acc = tv && !m_halt;
      hit = -1;
      for (int i = 0; i < NB; i++)
        if (hit < 0 && m_ben[i] && m_bid[i] == tid) hit = i;
      if (acc) begin
        if (exp_q.size() < D) exp_q.push_back(tid);
        else m_ovf = 1;
      end
      if (!(acc && exp_q.size() == D && m_ovf) && clr) begin
        m_ovf = (acc && !(exp_q.size() < D || exp_q[exp_q.size()-1] === tid)) ? 1'b1 : 1'b0;
      end
      if (!m_halt && acc && hit >= 0) begin
        m_halt = 1; m_slot = hit; m_hid = tid;
      end else if (m_halt && res) begin
        m_halt = 0;
      end
      if (bp_wr) begin m_bid[bp_idx] = bp_id; m_ben[bp_idx] = bp_en; end
    end
    @(posedge clk);
    #1;
    bp_wr = 1'b0; rst = 1'b0;
    chk("halt", 32'(halt), 32'(m_halt));
    chk("hit_slot", 32'(hit_slot), 32'(m_slot));
    chk("hit_id", hit_id, m_hid);
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() > 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  initial begin
    // reset
    step(0, 0, 0, 0, 0, 1);
    chk("rst_rd_id", rd_id, 0);

    // back-to-back record then readout
    step(1, 0, 0); step(1, 2, 0); step(1, 4, 0); step(1, 6, 0);
    chk("t1_head", rd_id, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1);

    // single breakpoint, events ignored while halted
    bp_set(1, 5, 1); step(0, 0, 0);
    step(1, 0, 0); step(1, 2, 0); step(1, 5, 0); step(1, 6, 0);
    chk("t2_halt", 32'(halt), 1);
    chk("t2_cnt", 32'(count), 3);
    step(0, 0, 0, 1);
    bp_set(1, 5, 0); step(1, 6, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1);

    // duplicate IDs, lowest slot wins; write and match same cycle
    bp_set(0, 3, 1); step(0, 0, 0);
    bp_set(3, 3, 1); step(0, 0, 0);
    step(1, 3, 0); chk("t3_slot0", 32'(hit_slot), 0);
    step(0, 0, 0, 1);
    bp_set(0, 3, 0); step(1, 3, 0); chk("t3_prewrite", 32'(halt), 1);
    step(0, 0, 0, 1);
    step(1, 3, 0); chk("t3_slot3", 32'(hit_slot), 3);
    step(0, 0, 0, 1);
    bp_set(3, 3, 0); step(0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);

    // overflow, clear, set-wins, full push+pop
    for (int i = 10; i <= 18; i++) step(1, i, 0);
    chk("t4_ovf", 32'(overflow), 1);
    step(1, 19, 0, 0, 1); chk("t4_setwins", 32'(overflow), 1);
    step(0, 0, 0, 0, 1);  chk("t4_clr", 32'(overflow), 0);
    step(1, 99, 1);       chk("t4_fullpp", 32'(count), 8);
    for (int i = 0; i < 9; i++) step(0, 0, 1);

    // reset while halted
    bp_set(2, 7, 1); step(0, 0, 0);
    step(1, 7, 0); chk("t5_halt", 32'(halt), 1);
    step(1, 8, 0, 0, 0, 1);
    chk("t5_cnt", 32'(count), 0);
    step(1, 7, 0); chk("t5_nohalt", 32'(halt), 0);
    step(0, 0, 1);

    // wrap: alternating push/pop
    for (int i = 0; i < 20; i++) begin
      step(1, 100 + i, 1);
      chk("wrap_cnt", 32'(count <= 1), 1);
    end
    step(0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bp_trace_unit.md
Name: bp_trace_unit

Overview:
- Hardware consumer of the per-statement trace events emitted by instrumented debug logic: one statement ID per event.
- Records every event in order into a FIFO for debugger readout.
- Compares each event against a programmable breakpoint table; on a hit, raises a halt to the clock-gating/stall controller until the debugger resumes.

Parameters:
- ID_WIDTH, 32, width of a statement ID.
- DEPTH, 8, trace FIFO entries; power of two, >= 2.
- NUM_BP, 4, breakpoint slots; power of two, >= 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- trace_valid  in  1  statement event present this cycle.
- trace_id  in  ID_WIDTH  statement ID of the event.
- bp_wr  in  1  write one breakpoint slot.
- bp_idx  in  $clog2(NUM_BP) (min 1)  slot index.
- bp_id  in  ID_WIDTH  statement ID stored in the slot.
- bp_en  in  1  enable bit stored in the slot.
- resume  in  1  debugger resume request.
- halt  out  1  design halted at a breakpoint.
- hit_slot  out  $clog2(NUM_BP) (min 1)  slot that caused the halt.
- hit_id  out  ID_WIDTH  statement ID that caused the halt.
- rd_valid  out  1  FIFO not empty.
- rd_id  out  ID_WIDTH  oldest recorded ID; valid when rd_valid=1.
- rd_ready  in  1  pop when rd_valid=1.
- count  out  $clog2(DEPTH)+1  entries held.
- overflow  out  1  sticky: an event was lost because the FIFO was full.
- clr_overflow  in  1  clear the overflow flag.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-halt): state RUN; FIFO emptied; all slots disabled with IDs 0; halt=0, hit_slot=0, hit_id=0, rd_valid=0, rd_id=0, count=0, overflow=0. rst has priority over all other inputs.
- FSM states: RUN, HALTED.
- RUN -> HALTED: trace_valid=1 and trace_id equals bp_id of any enabled slot.
  - halt=1 from the following cycle (1-cycle latency).
  - hit_slot = lowest matching index; hit_id = trace_id; both are held while HALTED.
- HALTED -> RUN: resume=1; halt=0 the following cycle. hit_slot and hit_id keep their values until the next hit.
- resume in RUN: ignored.
- Events while HALTED: ignored. No push, no match, no overflow.
- Breakpoint table:
  - bp_wr writes {bp_id, bp_en} into slot bp_idx at the edge, in either state.
  - A match in the same cycle as a write uses the pre-write contents.
  - Several slots may hold the same ID; the lowest index wins.
- Record path (RUN only): an accepted event is pushed, including the event that triggers the halt.
- FIFO:
  - Registered output, no fall-through: a push into an empty FIFO gives rd_valid=1 and the new rd_id on the next cycle.
  - Pop = rd_valid & rd_ready.
  - Push and pop in the same cycle: both happen, count unchanged, including when full.
  - Push while full without a pop: event dropped, overflow=1 from the next cycle, FIFO contents unchanged.
  - Pointers wrap modulo DEPTH. count = push - pop.
- overflow:
  - Cleared by clr_overflow at the edge.
  - If a drop and clr_overflow occur in the same cycle, set wins (overflow=1).
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Reset, then trace IDs 0,2,4,6 back-to-back with rd_ready=0 -> count=4, rd_id=0. Pop 4 cycles -> reads 0,2,4,6, then rd_valid=0, count=0.
- Slot 1 = {5,en}; trace 0,2,5,6 in RUN -> halt=1 the cycle after 5, hit_slot=1, hit_id=5, FIFO holds 0,2,5 (6 ignored). resume=1 -> halt=0 next cycle; following trace 6 recorded.
- Slots 0 and 3 both = {3,en}; trace 3 -> hit_slot=0. Disable slot 0 (bp_en=0) in the same cycle as trace 3 -> the halt still occurs; a later trace 3 gives hit_slot=3.
- DEPTH=8: push 9 IDs 10..18 with no pops -> count=8, overflow=1, readout 10..17. clr_overflow -> 0. With the FIFO full, push and pop together -> count stays 8, the new ID appears last.
- Assert rst while HALTED with the FIFO non-empty -> next cycle halt=0, count=0, rd_valid=0, overflow=0. A former breakpoint ID no longer halts (slots cleared).
- Wrap test: 20 alternating push/pop cycles with DEPTH=8 -> the ID order is preserved across pointer wrap, and count never exceeds 1.
